// File: rtl/tdm_demux_14.sv
// tdm_demux_14: 4:1 TDM receive deserialiser; optional frame counter enabled by TDM_FRAME_CNT_EN
module tdm_demux_14 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             frame_sync,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y_a,
  output logic [WIDTH-1:0] y_b,
  output logic [WIDTH-1:0] y_c,
  output logic [WIDTH-1:0] y_d,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
`ifdef TDM_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [1:0] slot, slot_n, idx;
  logic [WIDTH-1:0] h0, h1, h2;
  logic resync, wrap, capture;
  assign sel = slot;
  assign locked = state == RUN;
  // next state, slot advance and per-edge action decode
  always_comb begin
    state_n = (en && frame_sync) ? RUN : state;
    resync = en && state == RUN && frame_sync && slot != 2'd0;
    wrap = en && state == RUN && !resync && slot == 2'd3;
    capture = en && (state == RUN || frame_sync);
    idx = resync ? 2'd0 : slot;
    slot_n = !capture ? slot : resync ? 2'd1 : slot + 2'd1;
  end
  // state register; only reset leaves RUN
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // slot counter, holding registers, frame outputs and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      y_a <= '0;
      y_b <= '0;
      y_c <= '0;
      y_d <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      slot <= slot_n;
      frame_valid <= wrap;
      sync_err <= resync;
      if (capture && idx == 2'd0) h0 <= din;
      if (capture && idx == 2'd1) h1 <= din;
      if (capture && idx == 2'd2) h2 <= din;
      if (wrap) begin
        y_a <= h0;
        y_b <= h1;
        y_c <= h2;
        y_d <= din;
      end
    end
  end
`ifdef TDM_FRAME_CNT_EN
  // count completed frames, wrapping at 8 bits
  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt <= '0;
    else if (wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_tdm_demux_14.sv
// tb_tdm_demux_14: table vectors plus randomized run against a frame-level reference model
module tb_tdm_demux_14;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, frame_sync = 1'b0;
  logic [3:0] din = '0;
  logic [1:0] sel;
  logic [3:0] y_a, y_b, y_c, y_d;
  logic frame_valid, sync_err, locked;
`ifdef TDM_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif
  int errors = 0, checks = 0;

  tdm_demux_14 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame_sync(frame_sync),
    .sel(sel), .y_a(y_a), .y_b(y_b), .y_c(y_c), .y_d(y_d),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
`ifdef TDM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, e, fs;
    logic [3:0] d;
    logic [1:0] s;
    logic [15:0] y;
    logic fv, se, lk;
  } vec_t;
  vec_t tbl[$];

  bit m_lk, m_fv, m_se;
  int m_pos, m_cnt;
  logic [3:0] m_buf[4];
  logic [15:0] m_y;

  task automatic v(input logic r, e, fs, input logic [3:0] d, input logic [1:0] s,
                   input logic [15:0] y, input logic fv, se, lk);
    tbl.push_back('{r, e, fs, d, s, y, fv, se, lk});
  endtask

  task automatic step(input logic r, e, fs, input logic [3:0] d);
    rst_n = r; en = e; frame_sync = fs; din = d;
    @(posedge clk);
    m_fv = 0; m_se = 0;
    if (!r) begin
      m_lk = 0; m_pos = 0; m_y = '0; m_cnt = 0;
    end else if (e) begin
      if (!m_lk) begin
        if (fs) begin m_lk = 1; m_buf[0] = d; m_pos = 1; end
      end else if (fs && m_pos != 0) begin
        m_se = 1; m_buf[0] = d; m_pos = 1;
      end else begin
        m_buf[m_pos] = d;
        if (m_pos == 3) begin
          m_y = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
          m_fv = 1;
          m_cnt = (m_cnt + 1) % 256;
        end
        m_pos = (m_pos + 1) % 4;
      end
    end
    #1;
  endtask

  function automatic logic [20:0] dut_out();
    return {sel, y_a, y_b, y_c, y_d, frame_valid, sync_err, locked};
  endfunction

  task automatic chk(input string name, input logic [20:0] exp);
    checks++;
    if (dut_out() !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, dut_out(), exp);
    end
  endtask

  initial begin
    v(0,1,0,4'h0, 0,16'h0000,0,0,0);
    v(0,1,1,4'h5, 0,16'h0000,0,0,0);
    v(1,1,0,4'h7, 0,16'h0000,0,0,0);
    v(1,1,1,4'h1, 1,16'h0000,0,0,1);
    v(1,1,0,4'h0, 2,16'h0000,0,0,1);
    v(1,1,0,4'h1, 3,16'h0000,0,0,1);
    v(1,1,0,4'h1, 0,16'h1011,1,0,1);
    v(1,1,1,4'h2, 1,16'h1011,0,0,1);
    v(1,1,0,4'h3, 2,16'h1011,0,0,1);
    v(1,1,0,4'h4, 3,16'h1011,0,0,1);
    v(1,1,0,4'h5, 0,16'h2345,1,0,1);
    v(1,1,0,4'h6, 1,16'h2345,0,0,1);
    v(1,1,0,4'h7, 2,16'h2345,0,0,1);
    v(1,1,1,4'h8, 1,16'h2345,0,1,1);
    v(1,1,0,4'h9, 2,16'h2345,0,0,1);
    v(1,1,0,4'hA, 3,16'h2345,0,0,1);
    v(1,1,0,4'hB, 0,16'h89AB,1,0,1);
    v(1,1,0,4'h1, 1,16'h89AB,0,0,1);
    v(1,1,0,4'h2, 2,16'h89AB,0,0,1);
    for (int i = 0; i < 5; i++) v(1,0,1,4'hF, 2,16'h89AB,0,0,1);
    v(1,1,0,4'h3, 3,16'h89AB,0,0,1);
    v(1,1,0,4'h4, 0,16'h1234,1,0,1);
    v(1,1,0,4'h5, 1,16'h1234,0,0,1);
    v(1,1,0,4'h6, 2,16'h1234,0,0,1);
    v(0,1,0,4'h6, 0,16'h0000,0,0,0);
    v(1,1,0,4'h7, 0,16'h0000,0,0,0);
    v(1,1,0,4'h8, 0,16'h0000,0,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].fs, tbl[i].d);
      chk($sformatf("vec%0d", i), {tbl[i].s, tbl[i].y, tbl[i].fv, tbl[i].se, tbl[i].lk});
    end
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(7) == 0,
           4'($urandom));
      chk($sformatf("rand%0d", i), {2'(m_pos), m_y, m_fv, m_se, m_lk});
`ifdef TDM_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt%0d: got %0d expected %0d", i, frame_cnt, m_cnt);
      end
`endif
    end
`ifdef TDM_FRAME_CNT_EN
    step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 0, 2);
    step(1, 1, 1, 3);
    for (int f = 0; f < 257; f++)
      for (int s = 0; s < 4; s++) step(1, 1, s == 0, 4'(s));
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frame_cnt_257: got %0d expected 1", frame_cnt);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
